gtf_axil_master: RTL and testbench

Single-outstanding AXI4-Lite master that turns a simple command/response handshake into AXI-Lite read and write transactions. It drives the `s_axil_*` register port of the GTF top level from the `sys_if_clk` domain and is the initiator used by bring-up and test logic. A watchdog terminates any transaction the slave never completes, so a tied-off or hung slave cannot stall the caller.

---
 rtl/gtf_axil_pkg.sv | 8 +
 rtl/axil_watchdog.sv | 22 ++
 rtl/gtf_axil_master.sv | 149 ++++++++++++++
 tb/tb_gtf_axil_master.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gtf_axil_pkg.sv
// gtf_axil_pkg: FSM state, AXI response codes and watchdog width
// shared by the AXI-Lite master and its watchdog.
package gtf_axil_pkg;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam int WDOG_W = 16;
endpackage

// File: rtl/axil_watchdog.sv
// axil_watchdog: saturating cycle counter that flags an overlong AXI-Lite transaction.
module axil_watchdog
    import gtf_axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYCLES);
    logic [WDOG_W-1:0] cnt;
    // Flag the cycle whose increment reaches the limit so the caller aborts on that same edge.
    assign expired = enable && cnt >= LIMIT - 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable && cnt != LIMIT) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/gtf_axil_master.sv
// gtf_axil_master: single-outstanding AXI4-Lite master driven by a cmd/rsp handshake,
// with a watchdog that aborts transactions the slave never completes.
module gtf_axil_master
    import gtf_axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              sys_if_clk,
    input  logic              sys_if_rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_axil_awaddr,
    output logic [2:0]        m_axil_awprot,
    output logic              m_axil_awvalid,
    input  logic              m_axil_awready,
    output logic [31:0]       m_axil_wdata,
    output logic [3:0]        m_axil_wstrb,
    output logic              m_axil_wvalid,
    input  logic              m_axil_wready,
    input  logic [1:0]        m_axil_bresp,
    input  logic              m_axil_bvalid,
    output logic              m_axil_bready,
    output logic [ADDR_W-1:0] m_axil_araddr,
    output logic [2:0]        m_axil_arprot,
    output logic              m_axil_arvalid,
    input  logic              m_axil_arready,
    input  logic [31:0]       m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    input  logic              m_axil_rvalid,
    output logic              m_axil_rready
);
    state_t state;
    logic busy, expired, aw_ok, w_ok, done;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;
    assign busy = state != IDLE && state != RSP;
    always_comb begin
        aw_ok = !m_axil_awvalid || m_axil_awready;
        w_ok = !m_axil_wvalid || m_axil_wready;
        done = state == WR_REQ ? aw_ok && w_ok :
               state == WR_RESP ? m_axil_bvalid :
               state == RD_REQ ? m_axil_arready :
               state == RD_DATA ? m_axil_rvalid : 1'b0;
    end
    axil_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk(sys_if_clk),
        .rst_n(sys_if_rstn),
        .clear(cmd_valid && cmd_ready),
        .enable(busy),
        .expired(expired)
    );
    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp <= AXI_RESP_OKAY;
            rsp_timeout <= 1'b0;
            m_axil_awaddr <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wdata <= '0;
            m_axil_wstrb <= '0;
            m_axil_wvalid <= 1'b0;
            m_axil_bready <= 1'b0;
            m_axil_araddr <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cmd_ready <= 1'b0;
                    if (cmd_write) begin
                        state <= WR_REQ;
                        m_axil_awaddr <= cmd_addr;
                        m_axil_wdata <= cmd_wdata;
                        m_axil_wstrb <= cmd_wstrb;
                        m_axil_awvalid <= 1'b1;
                        m_axil_wvalid <= 1'b1;
                    end else begin
                        state <= RD_REQ;
                        m_axil_araddr <= cmd_addr;
                        m_axil_arvalid <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wready) m_axil_wvalid <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_axil_awvalid <= 1'b0;
                        m_axil_wvalid <= 1'b0;
                        m_axil_bready <= 1'b1;
                        state <= WR_RESP;
                    end
                end
                WR_RESP: if (m_axil_bvalid) begin
                    m_axil_bready <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_resp <= m_axil_bresp;
                    rsp_rdata <= '0;
                    rsp_timeout <= 1'b0;
                    state <= RSP;
                end
                RD_REQ: if (m_axil_arready) begin
                    m_axil_arvalid <= 1'b0;
                    m_axil_rready <= 1'b1;
                    state <= RD_DATA;
                end
                RD_DATA: if (m_axil_rvalid) begin
                    m_axil_rready <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_resp <= m_axil_rresp;
                    rsp_rdata <= m_axil_rdata;
                    rsp_timeout <= 1'b0;
                    state <= RSP;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A phase that completes on the expiry cycle takes precedence over the abort.
            if (busy && expired && !done) begin
                m_axil_awvalid <= 1'b0;
                m_axil_wvalid <= 1'b0;
                m_axil_bready <= 1'b0;
                m_axil_arvalid <= 1'b0;
                m_axil_rready <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_resp <= AXI_RESP_SLVERR;
                rsp_rdata <= '0;
                state <= RSP;
            end
        end
    end
endmodule

// File: tb/tb_gtf_axil_master.sv
// tb_gtf_axil_master: directed checks of gtf_axil_master with the slave
// side driven step by step from the stimulus block.
module tb_gtf_axil_master;
    logic sys_if_clk = 1'b0, sys_if_rstn = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0] cmd_wstrb = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0] awprot, arprot;
    logic [3:0] wstrb;
    logic awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0] bresp = 2'b00, rresp = 2'b00;
    logic bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic rvalid = 1'b0, rready;
    int vectors = 0, errs = 0, bcnt = 0, b0 = 0, aw_hi = 0, early = 0;

    gtf_axil_master #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .sys_if_clk(sys_if_clk), .sys_if_rstn(sys_if_rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    always #5 sys_if_clk = ~sys_if_clk;
    always @(posedge sys_if_clk) if (bvalid && bready) bcnt <= bcnt + 1;

    task automatic cyc();
        @(posedge sys_if_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) cyc();
        sys_if_rstn = 1'b1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));
        chk("rst_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}), 64'(0));
        chk("rst_axi", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
        chk("rst_addr", 64'({awaddr, araddr}), 64'(0));
        chk("prot", 64'({awprot, arprot}), 64'(0));
        // write, always-ready slave, B one cycle after W
        awready = 1; wready = 1;
        cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF; cmd_valid = 1;
        cyc();
        cmd_valid = 0;
        chk("w_valids", 64'({awvalid, wvalid, cmd_ready}), 64'(3'b110));
        chk("w_addr_data", {awaddr, wdata}, {32'h10, 32'hDEADBEEF});
        chk("w_strb", 64'(wstrb), 64'(4'hF));
        cyc();
        chk("w_bready", 64'({awvalid, wvalid, bready, rsp_valid}), 64'(4'b0010));
        bvalid = 1; bresp = 2'b00;
        cyc();
        bvalid = 0;
        chk("w_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp, bready}), 64'(5'b10000));
        chk("w_rdata", 64'(rsp_rdata), 64'(0));
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        chk("w_done", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
        // read with five wait cycles on rvalid
        arready = 1;
        cmd_write = 0; cmd_addr = 32'h20; cmd_valid = 1;
        cyc();
        cmd_valid = 0;
        chk("r_ar", {31'b0, arvalid, araddr}, {31'b0, 1'b1, 32'h20});
        cyc();
        chk("r_rready", 64'({arvalid, rready}), 64'(2'b01));
        repeat (5) cyc();
        chk("r_wait", 64'({rsp_valid, rready}), 64'(2'b01));
        rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
        cyc();
        rvalid = 0;
        chk("r_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp, rready}), 64'(5'b10000));
        chk("r_rdata", 64'(rsp_rdata), 64'(32'h12345678));
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        // write with awready delayed three cycles
        awready = 0; wready = 1; b0 = bcnt;
        cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'h3; cmd_valid = 1;
        cyc();
        cmd_valid = 0;
        aw_hi = int'(awvalid);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i == 1) chk("d_w_drop", 64'({awvalid, wvalid}), 64'(2'b10));
            if (i == 3) awready = 1;
            aw_hi += int'(awvalid);
        end
        chk("d_aw_cycles", 64'(aw_hi), 64'(4));
        chk("d_bready", 64'({bready, rsp_valid}), 64'(2'b10));
        bvalid = 1;
        cyc();
        chk("d_rsp", 64'({rsp_valid, bready, rsp_resp}), 64'(4'b1000));
        cyc();
        bvalid = 0;
        chk("d_one_b", 64'(bcnt - b0), 64'(1));
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        // slave never asserts awready: timeout after 16 cycles
        awready = 0; wready = 1;
        cmd_addr = 32'h44; cmd_valid = 1;
        cyc();
        cmd_valid = 0;
        early = 0;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            if (rsp_valid) early++;
        end
        chk("t_no_early", 64'(early), 64'(0));
        cyc();
        chk("t_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp}), 64'(4'b1110));
        chk("t_rdata", 64'(rsp_rdata), 64'(0));
        chk("t_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
        cyc();
        chk("t_hold", 64'({rsp_valid, rsp_timeout, rsp_resp, cmd_ready}), 64'(5'b11100));
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        chk("t_done", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
        // read returning SLVERR, then a stray rvalid in IDLE
        arready = 1;
        cmd_write = 0; cmd_addr = 32'h50; cmd_valid = 1;
        cyc();
        cmd_valid = 0;
        cyc();
        rvalid = 1; rdata = 32'hCAFE0001; rresp = 2'b10;
        cyc();
        rvalid = 0;
        chk("e_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp}), 64'(4'b1010));
        chk("e_rdata", 64'(rsp_rdata), 64'(32'hCAFE0001));
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        rvalid = 1; rdata = 32'h0BAD0BAD;
        cyc();
        chk("e_stray", 64'({rready, rsp_valid, cmd_ready}), 64'(3'b001));
        cyc();
        rvalid = 0;
        chk("e_stray2", 64'({rready, rsp_valid}), 64'(0));
        // reset during RD_DATA, then a normal write
        cmd_addr = 32'h60; cmd_valid = 1;
        cyc();
        cmd_valid = 0;
        cyc();
        chk("x_rd_data", 64'(rready), 64'(1'b1));
        sys_if_rstn = 0;
        #1;
        chk("x_rst_clear", 64'({rready, arvalid, rsp_valid, cmd_ready}), 64'(4'b0001));
        cyc();
        cyc();
        sys_if_rstn = 1;
        cyc();
        chk("x_after_rst", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
        awready = 1; wready = 1;
        cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'h5; cmd_valid = 1;
        cyc();
        cmd_valid = 0;
        chk("x_w_data", {awaddr, wdata}, {32'h40, 32'h0BADF00D});
        cyc();
        bvalid = 1; bresp = 2'b00;
        cyc();
        bvalid = 0;
        chk("x_w_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp}), 64'(4'b1000));
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        chk("x_idle", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
